// File: rtl/crc_engine_par.sv
// Parametrised LFSR CRC engine: accumulates a start/last framed payload, then
// either serialises the CRC MSB-first (GEN) or compares a received CRC (CHECK).
module crc_engine_par #(
    parameter int unsigned      CRC_W     = 24,
    parameter logic [CRC_W-1:0] POLY      = CRC_W'(32'h0000_065B),
    parameter int unsigned      BPC       = 1,
    parameter bit               INIT_SWAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_check,
    input  logic [CRC_W-1:0] crc_init,
    input  logic [BPC-1:0]   data_in,
    input  logic             data_in_valid,
    input  logic             data_in_last,
    output logic             data_in_ready,
    output logic [BPC-1:0]   crc_out,
    output logic             crc_out_valid,
    input  logic             crc_out_ready,
    output logic [CRC_W-1:0] lfsr,
    output logic             crc_done,
    output logic             crc_ok,
    output logic             busy
);

    localparam int unsigned NBEATS = CRC_W / BPC;
    localparam int unsigned CNT_W  = $clog2(NBEATS + 1);
    localparam int unsigned NBYTES = CRC_W / 8;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_EMIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             mode_r;
    logic [CRC_W-1:0] snap;
    logic [CNT_W-1:0] cnt;
    logic             ok_flag;

    logic [CRC_W-1:0] lfsr_nxt;
    logic [CRC_W-1:0] sh;
    logic [BPC-1:0]   exp_bits;
    logic             in_acc;
    logic             out_acc;
    logic             last_beat;
    logic             beat_match;

    // BPC serial LFSR steps, d[0] consumed first
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] cur,
                                                  input logic [BPC-1:0]   d);
        logic [CRC_W-1:0] v;
        logic [BPC-1:0]   dd;
        logic             nb;
        v  = cur;
        dd = d;
        for (int unsigned i = 0; i < BPC; i++) begin
            nb = v[CRC_W-1] ^ dd[0];
            v  = {v[CRC_W-2:0], 1'b0} ^ (nb ? POLY : '0);
            dd = dd >> 1;
        end
        return v;
    endfunction

    // Whole-byte order reversal; lowest byte of x lands in the top byte
    function automatic logic [CRC_W-1:0] byte_rev(input logic [CRC_W-1:0] x);
        logic [CRC_W-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            r = (r << 8) | ((x >> (8 * b)) & CRC_W'(8'hFF));
        end
        return r;
    endfunction

    assign in_acc     = data_in_valid & data_in_ready;
    assign out_acc    = crc_out_valid & crc_out_ready;
    assign last_beat  = (cnt == LAST_BEAT);
    assign lfsr_nxt   = crc_step(lfsr, data_in);
    assign beat_match = (data_in == exp_bits);

    // Snapshot bits for the current beat: exp_bits[i] = snap[W-1-(cnt*BPC+i)]
    always_comb begin
        sh       = snap << (32'(cnt) * BPC);
        exp_bits = '0;
        for (int unsigned i = 0; i < BPC; i++) begin
            exp_bits = (exp_bits >> 1) | (BPC'(sh[CRC_W-1]) << (BPC - 1));
            sh       = sh << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_ACCUM;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_ACCUM: if (in_acc && data_in_last) state_nxt = mode_r ? S_CHECK : S_EMIT;
                S_EMIT:  if (out_acc && last_beat)   state_nxt = S_DONE;
                S_CHECK: if (in_acc && last_beat)    state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        data_in_ready = 1'b0;
        crc_out_valid = 1'b0;
        crc_done      = 1'b0;
        busy          = (state != S_IDLE);
        crc_out       = exp_bits;
        case (state)
            S_ACCUM: data_in_ready = 1'b1;
            S_CHECK: data_in_ready = 1'b1;
            S_EMIT:  crc_out_valid = 1'b1;
            S_DONE:  crc_done      = 1'b1;
            default: ;
        endcase
    end

    // Datapath: start overrides everything and aborts any frame in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr    <= '0;
            snap    <= '0;
            cnt     <= '0;
            mode_r  <= 1'b0;
            ok_flag <= 1'b0;
            crc_ok  <= 1'b0;
        end else if (start) begin
            lfsr    <= INIT_SWAP ? byte_rev(crc_init) : crc_init;
            mode_r  <= mode_check;
            cnt     <= '0;
            ok_flag <= 1'b1;
            crc_ok  <= 1'b0;
        end else begin
            case (state)
                S_ACCUM: begin
                    if (in_acc) begin
                        lfsr <= lfsr_nxt;
                        if (data_in_last) begin
                            snap    <= lfsr_nxt;
                            cnt     <= '0;
                            ok_flag <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_acc) begin
                        cnt <= last_beat ? '0 : cnt + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (in_acc) begin
                        ok_flag <= ok_flag & beat_match;
                        if (last_beat) begin
                            crc_ok <= ok_flag & beat_match;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_engine_par.sv
// Bench for crc_engine_par: bit-serial CRC model, per-cycle compare process,
// directed frames in GEN/CHECK, aborts, resets and a BPC=8 vs BPC=1 cross-check.
module tb_crc_engine_par;

    localparam int unsigned W = 24;
    localparam logic [W-1:0] POLY = 24'h00065B;

    typedef logic bitq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start, mode_check, dv, dl, dready, cvalid, cready, done, ok, busy;
    logic [W-1:0] crc_init, lfsr;
    logic [0:0]   din, cout;

    logic         start8, dv8, dl8, dready8, cvalid8, cready8, done8, ok8, busy8;
    logic [W-1:0] init8, lfsr8;
    logic [7:0]   din8, cout8;

    crc_engine_par #(.CRC_W(W), .POLY(POLY), .BPC(1), .INIT_SWAP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_check(mode_check),
        .crc_init(crc_init), .data_in(din), .data_in_valid(dv), .data_in_last(dl),
        .data_in_ready(dready), .crc_out(cout), .crc_out_valid(cvalid),
        .crc_out_ready(cready), .lfsr(lfsr), .crc_done(done), .crc_ok(ok), .busy(busy)
    );

    crc_engine_par #(.CRC_W(W), .POLY(POLY), .BPC(8), .INIT_SWAP(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode_check(1'b0),
        .crc_init(init8), .data_in(din8), .data_in_valid(dv8), .data_in_last(dl8),
        .data_in_ready(dready8), .crc_out(cout8), .crc_out_valid(cvalid8),
        .crc_out_ready(cready8), .lfsr(lfsr8), .crc_done(done8), .crc_ok(ok8), .busy(busy8)
    );

    int       n_chk = 0;
    int       n_err = 0;
    int       o_idx = 0;
    int       done_seen = 0;
    int       done_exp = 0;
    bit       trk = 1'b0;
    logic [W-1:0] m_lfsr = '0;
    logic [W-1:0] m_snap = '0;
    logic     rx_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: polynomial long division one message bit at a time
    function automatic logic [W-1:0] m_bit(input logic [W-1:0] c, input logic d);
        if (c[W-1] ^ d) return (c << 1) ^ POLY;
        return c << 1;
    endfunction

    function automatic logic [W-1:0] m_swap(input logic [W-1:0] x);
        return {x[7:0], x[15:8], x[23:16]};
    endfunction

    function automatic bitq_t word_bits(input logic [W-1:0] v);
        bitq_t q;
        for (int k = 0; k < int'(W); k++) q.push_back(v[W-1-k]);
        return q;
    endfunction

    function automatic bitq_t pdu_bits(input int nbytes);
        bitq_t q;
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            b = 8'(i * 7 + 3);
            for (int j = 0; j < 8; j++) q.push_back(b[j]);
        end
        return q;
    endfunction

    // Per-cycle compare of the BPC=1 engine against the model
    always @(negedge clk) begin
        if (done) done_seen++;
        if (trk) begin
            chk("lfsr", 32'(lfsr), 32'(m_lfsr));
            if (cvalid) begin
                if (o_idx >= int'(W)) begin
                    chk("emit_overrun", 32'(o_idx), 32'(W - 1));
                end else begin
                    chk("crc_out", 32'(cout), 32'(m_snap[W-1-o_idx]));
                    if (cready) begin
                        rx_q.push_back(cout[0]);
                        o_idx++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic mc, input logic [W-1:0] init);
        start = 1'b1; mode_check = mc; crc_init = init; dv = 1'b0; dl = 1'b0;
        @(posedge clk);
        m_lfsr = m_swap(init);
        o_idx = 0;
        rx_q.delete();
        #1;
        start = 1'b0; cready = 1'b0;
        chk("start_ready", 32'(dready), 32'd1);
        chk("start_no_valid", 32'(cvalid), 32'd0);
        chk("start_ok_clear", 32'(ok), 32'd0);
    endtask

    task automatic send_payload(input bitq_t bits, input bit mark_last);
        for (int i = 0; i < bits.size(); i++) begin
            din = bits[i]; dv = 1'b1; dl = mark_last && (i == bits.size() - 1);
            @(posedge clk);
            m_lfsr = m_bit(m_lfsr, bits[i]);
            #1;
        end
        dv = 1'b0; dl = 1'b0;
        if (mark_last) m_snap = m_lfsr;
    endtask

    task automatic run_emit(input bit rnd);
        int cyc = 0;
        cready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (rx_q.size() < int'(W) && cyc < 400) begin
            tick();
            cyc++;
            if (rx_q.size() < int'(W)) cready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        cready = 1'b0;
        chk("emit_bits", 32'(rx_q.size()), 32'(W));
        chk("emit_done", 32'(done), 32'd1);
        chk("emit_done_valid_low", 32'(cvalid), 32'd0);
        done_exp++;
        tick();
        chk("emit_done_pulse", 32'(done), 32'd0);
        chk("emit_idle", 32'(busy), 32'd0);
    endtask

    task automatic run_check(input bitq_t bits, input logic exp_ok);
        for (int k = 0; k < bits.size(); k++) begin
            din = bits[k]; dv = 1'b1; dl = 1'(k % 2);
            tick();
        end
        dv = 1'b0; dl = 1'b0;
        chk("check_done", 32'(done), 32'd1);
        chk("check_ok", 32'(ok), 32'(exp_ok));
        done_exp++;
        tick();
        chk("check_done_pulse", 32'(done), 32'd0);
        chk("check_ok_held", 32'(ok), 32'(exp_ok));
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_lfsr"}, 32'(lfsr), 32'd0);
        chk({nm, "_ok"}, 32'(ok), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_ready"}, 32'(dready), 32'd0);
        chk({nm, "_valid"}, 32'(cvalid), 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        m_lfsr = '0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bitq_t      pdu, ble_crc, bad, part, bits64;
        logic [W-1:0] v, m8;
        logic [7:0] pl[64];
        logic [7:0] e8[3];

        rst_n = 1'b0; start = 1'b0; mode_check = 1'b0; crc_init = '0;
        din = '0; dv = 1'b0; dl = 1'b0; cready = 1'b0;
        start8 = 1'b0; init8 = '0; din8 = '0; dv8 = 1'b0; dl8 = 1'b0; cready8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        chk("reset8_lfsr", 32'(lfsr8), 32'd0);
        chk("reset8_busy", 32'(busy8), 32'd0);
        rst_n = 1'b1;
        trk = 1'b1;

        // One-bit frame from zero init: CRC equals the polynomial taps
        do_start(1'b0, 24'h000000);
        send_payload('{1'b1}, 1'b1);
        chk("one_bit_lfsr", 32'(lfsr), 32'h00065B);
        run_emit(1'b0);
        v = '0;
        foreach (rx_q[k]) v = {v[W-2:0], rx_q[k]};
        chk("one_bit_crc", 32'(v), 32'h00065B);

        // Init byte swap, then zero data
        do_start(1'b0, 24'h123456);
        chk("init_swap", 32'(lfsr), 32'h563412);
        send_payload('{0, 0, 0, 0, 0, 0, 0, 0}, 1'b1);
        run_emit(1'b0);

        // Two bits 1,0 from zero give 0x000CB6; checking that value passes
        do_start(1'b1, 24'h000000);
        send_payload('{1'b1, 1'b0}, 1'b1);
        chk("two_bit_lfsr", 32'(lfsr), 32'h000CB6);
        run_check(word_bits(24'h000CB6), 1'b1);
        repeat (3) tick();
        chk("ok_held_idle", 32'(ok), 32'd1);

        // Abort mid-CHECK, then mid-EMIT; neither may raise crc_done
        part = pdu_bits(3);
        do_start(1'b1, 24'h555555);
        send_payload(part, 1'b1);
        for (int k = 0; k < 10; k++) begin
            din = m_snap[W-1-k]; dv = 1'b1; tick();
        end
        dv = 1'b0;
        do_start(1'b0, 24'hABCDEF);
        chk("abort_chk_busy", 32'(busy), 32'd1);
        send_payload(part, 1'b1);
        cready = 1'b1;
        repeat (7) tick();
        do_start(1'b1, 24'h555555);
        send_payload(part, 1'b1);
        bad = word_bits(m_snap);
        run_check(bad, 1'b1);
        chk("done_after_aborts", 32'(done_seen), 32'(done_exp));

        // BLE PDU: GEN with backpressure, then loop the CRC back through CHECK
        pdu = pdu_bits(37);
        do_start(1'b0, 24'h555555);
        send_payload(pdu, 1'b1);
        run_emit(1'b1);
        ble_crc = rx_q;
        bad = ble_crc;
        bad[5] = ~bad[5];
        do_start(1'b1, 24'h555555);
        send_payload(pdu, 1'b1);
        run_check(bad, 1'b0);
        do_start(1'b1, 24'h555555);
        send_payload(pdu, 1'b1);
        run_check(ble_crc, 1'b1);
        pulse_reset();
        chk("reset_idle_ok", 32'(ok), 32'd0);

        // Reset in the middle of a frame
        do_start(1'b0, 24'h0F0F0F);
        send_payload(part, 1'b0);
        pulse_reset();
        chk_reset_outs("reset_mid");

        // BPC=8 engine vs BPC=1 engine on the same random payload
        foreach (pl[b]) pl[b] = 8'($urandom);
        bits64.delete();
        foreach (pl[b]) for (int j = 0; j < 8; j++) bits64.push_back(pl[b][j]);
        start8 = 1'b1; init8 = 24'h555555;
        tick();
        start8 = 1'b0;
        m8 = m_swap(init8);
        chk("bpc8_init", 32'(lfsr8), 32'(m8));
        for (int b = 0; b < 64; b++) begin
            din8 = pl[b]; dv8 = 1'b1; dl8 = (b == 63);
            tick();
            for (int j = 0; j < 8; j++) m8 = m_bit(m8, pl[b][j]);
        end
        dv8 = 1'b0; dl8 = 1'b0;
        chk("bpc8_lfsr", 32'(lfsr8), 32'(m8));
        cready8 = 1'b1;
        for (int bt = 0; bt < 3; bt++) begin
            for (int j = 0; j < 8; j++) e8[bt][j] = m8[W-1-(8*bt+j)];
            chk("bpc8_valid", 32'(cvalid8), 32'd1);
            chk("bpc8_crc_byte", 32'(cout8), 32'(e8[bt]));
            e8[bt] = cout8;
            tick();
        end
        cready8 = 1'b0;
        chk("bpc8_done_3beats", 32'(done8), 32'd1);
        tick();
        chk("bpc8_done_pulse", 32'(done8), 32'd0);

        do_start(1'b0, 24'h555555);
        send_payload(bits64, 1'b1);
        chk("bpc1_vs_bpc8_lfsr", 32'(lfsr), 32'(lfsr8));
        run_emit(1'b0);
        for (int bt = 0; bt < 3; bt++) begin
            v = '0;
            for (int j = 0; j < 8; j++) v[j] = rx_q[8*bt+j];
            chk("bpc1_vs_bpc8_byte", 32'(v[7:0]), 32'(e8[bt]));
        end

        repeat (2) tick();
        chk("done_count", 32'(done_seen), 32'(done_exp));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
